// File: rtl/signed_acc_pkg.sv
// Shared types and limit helpers for the signed saturating frame accumulator.
// The limit helpers return patterns up to MAX_WIDTH bits wide; callers slice them to size.
package signed_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    localparam int MAX_WIDTH = 64;

    // Largest positive two's-complement value of the given width: 0111..1
    function automatic logic [MAX_WIDTH-1:0] smax(input int width);
        smax = (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width: 1000..0
    function automatic logic [MAX_WIDTH-1:0] smin(input int width);
        smin = 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/signed_add_sat.sv
// Combinational two's-complement adder with overflow detect.
// Clamping to the signed limits is compiled in with SIGNED_ACC_SATURATE_EN; otherwise the sum wraps.
module signed_add_sat
    import signed_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    logic [WIDTH-1:0] s;

    assign s = a + b;

    // Only same-sign operands can overflow, and they do so when the sign of the sum flips.
    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);

`ifdef SIGNED_ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] POS_LIM = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] NEG_LIM = WIDTH'(smin(WIDTH));

    assign res = ovf ? (a[WIDTH-1] ? NEG_LIM : POS_LIM) : s;
`else
    assign res = s;
`endif

endmodule

// File: rtl/signed_sat_accumulator.sv
// Framed signed accumulator: sums LEN samples per frame and presents the sum with a sticky overflow flag.
// Build option SIGNED_ACC_SATURATE_EN selects clamping instead of modular wrap on overflow.
module signed_sat_accumulator
    import signed_acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_vld,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_sum,
    output logic             down_overflow
);

    localparam int             CW   = $clog2(LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(LEN - 1);

    acc_state_t       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;

    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    signed_add_sat #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (acc_q),
        .b   (up_data),
        .res (sum_d),
        .ovf (ovf_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (up_vld) begin
                        acc_q <= sum_d;
                        ovf_q <= ovf_q | ovf_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Result is held in acc_q/ovf_q until the consumer takes it.
                    if (down_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
            endcase
        end
    end

    assign up_ready      = (state_q == ACCUM);
    assign down_vld      = (state_q == DONE);
    assign down_sum      = acc_q;
    assign down_overflow = ovf_q;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Bench for signed_sat_accumulator: LEN=4 and LEN=1 instances share one stimulus stream
// and are checked every cycle against an integer-arithmetic frame model.
module tb_signed_sat_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_vld;
    logic [3:0] up_data;
    logic       down_ready;

    logic       up_ready4, down_vld4, down_ovf4;
    logic [3:0] down_sum4;
    logic       up_ready1, down_vld1, down_ovf1;
    logic [3:0] down_sum1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: index 0 is LEN=4, index 1 is LEN=1.
    int m_len [2] = '{4, 1};
    int m_acc [2];
    int m_cnt [2];
    bit m_ovf [2];
    bit m_pend[2];

    always #5 clk = ~clk;

    signed_sat_accumulator #(.WIDTH(4), .LEN(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .up_vld        (up_vld),
        .up_ready      (up_ready4),
        .up_data       (up_data),
        .down_vld      (down_vld4),
        .down_ready    (down_ready),
        .down_sum      (down_sum4),
        .down_overflow (down_ovf4)
    );

    signed_sat_accumulator #(.WIDTH(4), .LEN(1)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .up_vld        (up_vld),
        .up_ready      (up_ready1),
        .up_data       (up_data),
        .down_vld      (down_vld1),
        .down_ready    (down_ready),
        .down_sum      (down_sum1),
        .down_overflow (down_ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Add a sample to the model's running sum using plain integer range checks.
    task automatic model_add(input int i, input logic [3:0] d);
        int sd, exact;
        sd    = $signed(d);
        exact = m_acc[i] + sd;
        if (exact > 7 || exact < -8) begin
            m_ovf[i] = 1'b1;
`ifdef SIGNED_ACC_SATURATE_EN
            exact = (exact > 7) ? 7 : -8;
`else
            exact = ((exact + 24) % 16) - 8;
`endif
        end
        m_acc[i] = exact;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_pend[i] = 1'b0;
        end
    endtask

    task automatic check_state();
        logic [3:0] e4, e1;
        e4 = 4'(m_acc[0]);
        e1 = 4'(m_acc[1]);
        chk("L4 up_ready", 32'(up_ready4), 32'(!m_pend[0]));
        chk("L4 down_vld", 32'(down_vld4), 32'(m_pend[0]));
        if (m_pend[0]) begin
            chk("L4 down_sum", 32'(down_sum4), 32'(e4));
            chk("L4 down_overflow", 32'(down_ovf4), 32'(m_ovf[0]));
        end
        chk("L1 up_ready", 32'(up_ready1), 32'(!m_pend[1]));
        chk("L1 down_vld", 32'(down_vld1), 32'(m_pend[1]));
        if (m_pend[1]) begin
            chk("L1 down_sum", 32'(down_sum1), 32'(e1));
            chk("L1 down_overflow", 32'(down_ovf1), 32'(m_ovf[1]));
        end
    endtask

    // One clock cycle: drive at the negedge, update the model, check at the next negedge.
    task automatic step(input bit vld, input logic [3:0] d, input bit rdy);
        up_vld = vld; up_data = d; down_ready = rdy;
        for (int i = 0; i < 2; i++) begin
            if (!m_pend[i]) begin
                if (vld) begin
                    model_add(i, d);
                    m_cnt[i]++;
                    if (m_cnt[i] == m_len[i]) m_pend[i] = 1'b1;
                end
            end else if (rdy) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_pend[i] = 1'b0;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic frame(input logic [3:0] a, b, c, d);
        step(1'b1, a, 1'b1);
        step(1'b1, b, 1'b1);
        step(1'b1, c, 1'b1);
        step(1'b1, d, 1'b1);
        $display("frame %0d,%0d,%0d,%0d: sum=%0d ovf=%0d vld=%0d", $signed(a), $signed(b),
                 $signed(c), $signed(d), $signed(down_sum4), down_ovf4, down_vld4);
        step(1'b0, 4'h0, 1'b1);
    endtask

    // Asserted just after a negedge; outputs must clear without waiting for a clock edge.
    task automatic reset_now(input string tag);
        rst = 1'b1;
        #1;
        model_clear();
        chk({tag, " up_ready"}, 32'(up_ready4), 32'd1);
        chk({tag, " down_vld"}, 32'(down_vld4), 32'd0);
        chk({tag, " down_sum"}, 32'(down_sum4), 32'd0);
        chk({tag, " down_overflow"}, 32'(down_ovf4), 32'd0);
        chk({tag, " L1 down_vld"}, 32'(down_vld1), 32'd0);
        $display("reset %s: up_ready=%0d down_vld=%0d", tag, up_ready4, down_vld4);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; up_vld = 1'b0; up_data = 4'h0; down_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_now("por");

        frame(4'd1, 4'd2, 4'd3, 4'd1);
        frame(4'd4, 4'd4, 4'hF, 4'd0);
        frame(4'h8, 4'hF, 4'hF, 4'd2);

        // Backpressure: result must hold while further samples are offered and refused.
        for (int k = 0; k < 4; k++) step(1'b1, 4'd1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 4'd5, 1'b0);
        $display("backpressure: sum=%0d vld=%0d up_ready=%0d", $signed(down_sum4), down_vld4, up_ready4);
        step(1'b0, 4'h0, 1'b1);
        frame(4'd2, 4'd0, 4'd0, 4'd1);

        // Reset mid-frame, then a clean frame.
        step(1'b1, 4'd3, 1'b1);
        step(1'b1, 4'd3, 1'b1);
        reset_now("mid");
        frame(4'd1, 4'd0, 4'd0, 4'd0);

        // Reset while a result is pending.
        for (int k = 0; k < 4; k++) step(1'b1, 4'd2, 1'b0);
        reset_now("done");
        step(1'b0, 4'h0, 1'b1);

        // LEN=1 path: 5, gap, -3.
        step(1'b1, 4'd5, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'hD, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
            if (down_vld4 && down_ready)
                $display("rand frame: sum=%0d ovf=%0d", $signed(down_sum4), down_ovf4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
